// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: next-PC select encoding, fetch FSM
// states and the default reset vector.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // 2'b11 is left undefined and treated as PC+4 by pc_next.
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'b00,
    FETCH_WAIT  = 2'b01,
    FETCH_HOLD  = 2'b10,
    FETCH_FAULT = 2'b11
  } fetch_state_t;

  function automatic logic addr_misaligned(input logic [1:0] addr_lsb);
    return |addr_lsb;
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: PC+4, PC-relative target or JALR target,
// plus a flag for targets that are not word aligned.
module pc_next
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN
) (
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [1:0]            pc_src_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [DATA_WIDTH-1:0] jalr_target_i,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic [DATA_WIDTH-1:0] next_pc_o,
  output logic                  misaligned_o
);

  localparam logic [DATA_WIDTH-1:0] FOUR      = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] JALR_MASK = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

  logic [DATA_WIDTH-1:0] branch_target;

  // Both adders wrap modulo 2^DATA_WIDTH; the immediate is already sign-extended.
  assign pc_plus4_o    = pc_i + FOUR;
  assign branch_target = pc_i + imm_i;

  always_comb begin
    // NOTE: default assignment first so every path drives next_pc_o and no latch is inferred.
    next_pc_o = pc_plus4_o;
    case (pc_src_i)
      PC_BRANCH: next_pc_o = branch_target;
      PC_JALR:   next_pc_o = jalr_target_i & JALR_MASK;
      default:   next_pc_o = pc_plus4_o;
    endcase
  end

  assign misaligned_o = addr_misaligned(next_pc_o[1:0]);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time and
// holds the returned instruction until downstream retires it.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  input  logic [1:0]            PCSrc_i,
  input  logic [DATA_WIDTH-1:0] ImmOp_i,
  input  logic [DATA_WIDTH-1:0] jalr_target_i,
  output logic                  fetch_fault_o
);

  fetch_state_t          state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  req_q;
  logic                  valid_q;
  logic                  fault_q;

  logic [DATA_WIDTH-1:0] next_pc_d;
  logic                  next_misaligned;

  pc_next #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pc_next (
    .pc_i          (pc_q),
    .pc_src_i      (PCSrc_i),
    .imm_i         (ImmOp_i),
    .jalr_target_i (jalr_target_i),
    .pc_plus4_o    (pc_plus4_o),
    .next_pc_o     (next_pc_d),
    .misaligned_o  (next_misaligned)
  );

  // Outputs are registered alongside the state so each is a clean flop output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: non-blocking assignments throughout, so every register sees the pre-edge values.
      state_q <= FETCH_REQ;
      pc_q    <= RESET_PC;
      // NOTE: the instruction register is reset because instr_o = 0 is visible after reset.
      instr_q <= '0;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH_REQ: begin
          // rvalid is ignored here so a response left over from before a reset is dropped.
          if (imem_gnt_i) begin
            state_q <= FETCH_WAIT;
            req_q   <= 1'b0;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid_i) begin
            instr_q <= imem_rdata_i;
            state_q <= FETCH_HOLD;
            valid_q <= 1'b1;
          end
        end
        FETCH_HOLD: begin
          if (instr_ready_i) begin
            valid_q <= 1'b0;
            if (next_misaligned) begin
              state_q <= FETCH_FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_q    <= next_pc_d;
              state_q <= FETCH_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        FETCH_FAULT: begin
          state_q <= FETCH_FAULT;
        end
        default: begin
          state_q <= FETCH_FAULT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;
  assign fetch_fault_o = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: the bench plays instruction memory and the
// downstream consumer, with expected fetches queued and compared on delivery.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [1:0]  PCSrc_i;
  logic [31:0] ImmOp_i;
  logic [31:0] jalr_target_i;
  logic        fetch_fault_o;

  fetch_stage #(
    .DATA_WIDTH (32),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .PCSrc_i       (PCSrc_i),
    .ImmOp_i       (ImmOp_i),
    .jalr_target_i (jalr_target_i),
    .fetch_fault_o (fetch_fault_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_exp_t;

  fetch_exp_t  sb_q[$];
  logic [31:0] exp_pc;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] src,
                                             input logic [31:0] imm, input logic [31:0] jalr);
    case (src)
      2'b01:   return pc + imm;
      2'b10:   return {jalr[31:1], 1'b0};
      default: return pc + 32'd4;
    endcase
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    exp_pc = RST_PC;
    sb_q.delete();
    check("rst_req",   {31'b0, imem_req_o},    32'd1);
    check("rst_addr",  imem_addr_o,            RST_PC);
    check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_instr", instr_o,                32'd0);
    check("rst_pc",    pc_o,                   RST_PC);
    check("rst_fault", {31'b0, fetch_fault_o}, 32'd0);
  endtask

  // Memory side: wait for a request, grant after gnt_dly cycles, respond rv_dly
  // cycles after the grant cycle. The consumer pulses ready with a branch while
  // nothing is valid; that must have no effect.
  task automatic fetch(input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
    int i;
    for (i = 0; i < 20 && !imem_req_o; i++) step();
    if (!imem_req_o) begin
      check("req_timeout", {31'b0, imem_req_o}, 32'd1);
      return;
    end
    check("req_addr", imem_addr_o, exp_pc);
    repeat (gnt_dly) begin
      step();
      check("req_hold", {imem_addr_o[31:1], imem_req_o}, {exp_pc[31:1], 1'b1});
    end
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    check("wait_req_low", {31'b0, imem_req_o}, 32'd0);
    instr_ready_i = 1'b1;
    PCSrc_i       = 2'b01;
    ImmOp_i       = 32'h40;
    repeat (rv_dly) begin
      check("wait_no_valid", {31'b0, instr_valid_o}, 32'd0);
      step();
    end
    instr_ready_i = 1'b0;
    PCSrc_i       = 2'b00;
    ImmOp_i       = 32'h0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = rdata;
    step();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    check("valid_latency", {31'b0, instr_valid_o}, 32'd1);
    sb_q.push_back('{pc: exp_pc, instr: rdata});
  endtask

  // Consumer side: compare the held instruction against the scoreboard, keep it
  // unconsumed for hold cycles, then retire with the given next-PC select.
  task automatic retire(input logic [1:0] src, input logic [31:0] imm,
                        input logic [31:0] jalr, input int hold);
    fetch_exp_t  e;
    logic [31:0] nxt;
    int i;
    for (i = 0; i < 20 && !instr_valid_o; i++) step();
    if (!instr_valid_o || sb_q.size() == 0) begin
      check("valid_timeout", {31'b0, instr_valid_o}, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check("instr", instr_o, e.instr);
    check("pc", pc_o, e.pc);
    check("pc_plus4", pc_plus4_o, e.pc + 32'd4);
    repeat (hold) begin
      step();
      check("hold_instr", instr_o, e.instr);
      check("hold_valid", {31'b0, instr_valid_o}, 32'd1);
    end
    nxt = model_next(e.pc, src, imm, jalr);
    instr_ready_i = 1'b1;
    PCSrc_i       = src;
    ImmOp_i       = imm;
    jalr_target_i = jalr;
    step();
    instr_ready_i = 1'b0;
    PCSrc_i       = 2'b00;
    ImmOp_i       = 32'h0;
    jalr_target_i = 32'h0;
    check("post_retire_valid", {31'b0, instr_valid_o}, 32'd0);
    if (nxt[1:0] != 2'b00) begin
      check("fault_set", {31'b0, fetch_fault_o}, 32'd1);
      check("fault_no_req", {31'b0, imem_req_o}, 32'd0);
      check("fault_pc_kept", pc_o, e.pc);
    end else begin
      exp_pc = nxt;
      check("next_req", {31'b0, imem_req_o}, 32'd1);
      check("next_addr", imem_addr_o, nxt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0;
    instr_ready_i = 1'b0;
    PCSrc_i = 2'b00;
    ImmOp_i = 32'h0;
    jalr_target_i = 32'h0;
    exp_pc = RST_PC;

    do_reset();

    // First fetch with minimum latency, then sequential retires with varied delays.
    fetch(32'h0050_0093, 0, 0);
    retire(2'b00, 32'h0, 32'h0, 2);
    fetch(32'h0010_0113, 1, 2);
    retire(2'b00, 32'h0, 32'h0, 0);
    fetch(32'h0020_8193, 2, 3);
    retire(2'b00, 32'h0, 32'h0, 1);
    fetch(32'h0031_0233, 3, 1);
    retire(2'b00, 32'h0, 32'h0, 0);

    // Branch backwards from 0x10 to 0x08, then JALR with bit 0 cleared.
    fetch(32'hFE00_0CE3, 0, 0);
    retire(2'b01, 32'hFFFF_FFF8, 32'h0, 0);
    fetch(32'h0000_8067, 0, 2);
    retire(2'b10, 32'h0, 32'h0000_0101, 0);

    // Select 11 behaves as PC+4.
    fetch(32'h0000_0013, 1, 0);
    retire(2'b11, 32'h0000_0100, 32'h0000_0200, 0);

    // Jump to the top word and wrap to 0.
    fetch(32'h0000_00E7, 0, 0);
    retire(2'b10, 32'h0, 32'hFFFF_FFFC, 0);
    fetch(32'h0000_0073, 0, 1);
    retire(2'b00, 32'h0, 32'h0, 0);

    // Misaligned branch target faults; memory activity must not wake the stage.
    fetch(32'h0020_006F, 0, 0);
    retire(2'b01, 32'h0000_0002, 32'h0, 0);
    imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b1;
    instr_ready_i = 1'b1;
    repeat (3) begin
      step();
      check("fault_sticky", {29'b0, fetch_fault_o, imem_req_o, instr_valid_o}, 32'b100);
    end
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    instr_ready_i = 1'b0;
    do_reset();
    fetch(32'h0050_0093, 0, 0);
    retire(2'b00, 32'h0, 32'h0, 0);

    // Reset while waiting for data; a stale response right after reset is dropped.
    for (int i = 0; i < 20 && !imem_req_o; i++) step();
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    step();
    imem_rvalid_i = 1'b0;
    exp_pc = RST_PC;
    sb_q.delete();
    check("stale_valid", {31'b0, instr_valid_o}, 32'd0);
    check("stale_req",   {31'b0, imem_req_o},    32'd1);
    check("stale_addr",  imem_addr_o,            RST_PC);
    step();
    check("stale_valid_later", {31'b0, instr_valid_o}, 32'd0);
    fetch(32'h0000_0513, 0, 0);
    retire(2'b00, 32'h0, 32'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the single-cycle RISC-V core. It owns the program counter and issues one instruction-memory request at a time. It holds each returned instruction stable for the decode/sign-extension logic until that instruction is consumed, then computes the next PC. The next PC is PC+4, a PC-relative target using the sign-extended immediate (branch/JAL), or a register target (JALR).

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, addresses, instruction and immediate
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- imem_req_o  output  1  instruction-memory request valid
- imem_addr_o  output  DATA_WIDTH  request address (current PC)
- imem_gnt_i  input  1  memory accepted request this cycle
- imem_rvalid_i  input  1  read data valid
- imem_rdata_i  input  DATA_WIDTH  read data (instruction word)
- instr_o  output  DATA_WIDTH  held instruction, to decoder and sign extension
- pc_o  output  DATA_WIDTH  PC of instr_o
- pc_plus4_o  output  DATA_WIDTH  pc_o + 4, for JAL/JALR link value
- instr_valid_o  output  1  instr_o/pc_o are valid
- instr_ready_i  input  1  downstream retires instr_o this cycle
- PCSrc_i  input  2  next-PC select, sampled on retire: 00 PC+4, 01 PC+ImmOp_i, 10 jalr_target_i with bit 0 cleared, 11 treated as 00
- ImmOp_i  input  DATA_WIDTH  sign-extended immediate for the held instruction
- jalr_target_i  input  DATA_WIDTH  rs1+imm from ALU
- fetch_fault_o  output  1  misaligned fetch target; sticky until reset

## Operation
- The FSM has four states: REQ, WAIT, HOLD and FAULT. Reset state is REQ, with PC = RESET_PC.
- REQ:
  - imem_req_o = 1 and imem_addr_o = PC; both are held stable until imem_gnt_i.
  - On gnt, go to WAIT.
  - imem_rvalid_i is ignored in REQ, so a stale response after a mid-operation reset is dropped.
- WAIT:
  - imem_req_o = 0.
  - On imem_rvalid_i, capture imem_rdata_i into the instruction register and go to HOLD.
- HOLD:
  - instr_valid_o = 1; instr_o and pc_o are stable.
  - On instr_ready_i, compute next PC from PCSrc_i, ImmOp_i and jalr_target_i in that same cycle, load it into PC, and go to REQ.
  - If next PC[1:0] != 0, PC is not updated and the FSM goes to FAULT instead of REQ.
- FAULT:
  - All request and valid outputs are 0 and fetch_fault_o = 1.
  - The FSM leaves FAULT only on rst_i.
- Arithmetic is modulo 2^DATA_WIDTH, so PC+4 at 32'hFFFF_FFFC wraps to 0. PC+ImmOp also wraps; ImmOp_i is already sign-extended.
- Only one request is outstanding at a time, so there is no wrong-path fetch and no flush logic.

## Timing
- Reset values: PC = RESET_PC; imem_req_o = 1 in the cycle after reset deasserts; instr_valid_o = 0; instr_o = 0; pc_o = RESET_PC; fetch_fault_o = 0.
- Latency with gnt in the first REQ cycle and rvalid one cycle later:
  - gnt at cycle N.
  - rvalid at N+1.
  - instr_valid_o = 1 at N+2.
  - Retire at N+2 puts the next request at N+3.
- Minimum loop is 3 cycles per instruction.
- imem_rvalid_i is never expected in the same cycle as gnt. If it is, it is ignored.
- rst_i overrides every state in any cycle.
- instr_ready_i is ignored when instr_valid_o = 0.

## Structure
- A shared package riscv_pkg holds:
  - the PCSrc encoding enum (PC_PLUS4, PC_BRANCH, PC_JALR);
  - the fetch_state_t enum;
  - the default RESET_PC.
- One sub-module, pc_next: a combinational next-PC mux and adders producing next_pc and a misaligned flag. It is reused by later pipelined variants.

## Test plan
- Reset, then gnt on the first cycle and rvalid one cycle later with 32'h00500093 -> imem_addr_o = 0; instr_o = 32'h00500093 and pc_o = 0 with valid two cycles after gnt.
- Retire with PCSrc 00 three times, memory delay 0–3 cycles -> addresses 0, 4, 8, 12; instr_o stable while valid and not ready.
- Retire at pc = 32'h10 with PCSrc 01 and ImmOp = 32'hFFFF_FFF8 -> next imem_addr_o = 32'h08. Retire with PCSrc 10 and jalr_target = 32'h101 -> next address 32'h100.
- PC = 32'hFFFF_FFFC with PCSrc 00 -> next address 0 (wrap).
- PCSrc 01 with ImmOp = 32'h2 -> fetch_fault_o = 1, no further imem_req_o; rst_i -> fault cleared and fetch restarts at RESET_PC.
- Assert rst_i while in WAIT, then rvalid arrives in the first post-reset cycle -> response dropped, instr_valid_o stays 0, request to RESET_PC reissued.
